// File: rtl/l1_tag_ctrl_if.sv
// l1_tag_ctrl_if -- bus bundle for the L1 tag hit/miss controller.
//
// Groups the three interfaces the controller sits between:
//   core side : req_valid/req_ready/req_addr/req_we, resp_valid/resp_hit/resp_index
//   tag SRAM  : tag_ren/tag_raddr/tag_rdata (1-cycle read), tag_wen/tag_waddr/tag_wdata
//   arbiter   : mem_req_valid/mem_req_ready/mem_req_addr/mem_req_wb/mem_req_wb_addr,
//               mem_fill_done
// Modports:
//   slave  -- the controller (l1_tag_ctrl)
//   master -- the environment (core, tag SRAM, memory arbiter)
interface l1_tag_ctrl_if #(
    parameter int ADDR_W   = 32,
    parameter int INDEX_W  = 8,
    parameter int OFFSET_W = 7
);
    localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;

    logic                 req_valid;
    logic                 req_ready;
    logic [ADDR_W-1:0]    req_addr;
    logic                 req_we;
    logic                 resp_valid;
    logic                 resp_hit;
    logic [INDEX_W-1:0]   resp_index;

    logic                 tag_ren;
    logic [INDEX_W-1:0]   tag_raddr;
    logic [TAG_W+1:0]     tag_rdata;
    logic                 tag_wen;
    logic [INDEX_W-1:0]   tag_waddr;
    logic [TAG_W+1:0]     tag_wdata;

    logic                 mem_req_valid;
    logic                 mem_req_ready;
    logic [ADDR_W-1:0]    mem_req_addr;
    logic                 mem_req_wb;
    logic [ADDR_W-1:0]    mem_req_wb_addr;
    logic                 mem_fill_done;

    modport slave (
        input  req_valid, req_addr, req_we, tag_rdata, mem_req_ready, mem_fill_done,
        output req_ready, resp_valid, resp_hit, resp_index,
               tag_ren, tag_raddr, tag_wen, tag_waddr, tag_wdata,
               mem_req_valid, mem_req_addr, mem_req_wb, mem_req_wb_addr
    );

    modport master (
        output req_valid, req_addr, req_we, tag_rdata, mem_req_ready, mem_fill_done,
        input  req_ready, resp_valid, resp_hit, resp_index,
               tag_ren, tag_raddr, tag_wen, tag_waddr, tag_wdata,
               mem_req_valid, mem_req_addr, mem_req_wb, mem_req_wb_addr
    );
endinterface

// File: rtl/l1_tag_ctrl.sv
// l1_tag_ctrl -- hit/miss controller for the L1 tag store
// (256 sets x {valid, dirty, tag} entries in a 1R1W SRAM, 128-byte lines).
//
// Ports:
//   clk        clock
//   rst        synchronous active-high reset; all outputs read 0 while asserted
//   bus        l1_tag_ctrl_if.slave: core request/response, tag SRAM ports,
//              memory arbiter fill/write-back request and fill completion
//   hit_count  responses with resp_hit=1 (saturating, 32 bit)
//   miss_count responses with resp_hit=0 (saturating, 32 bit)
//
// Build option: define L1_TAG_PERF_CNT_EN to implement hit_count/miss_count;
// without it both ports are tied to 0.
//
// Flow: INIT clears every entry, IDLE accepts a request and reads its set,
// COMPARE answers hits (marking the line dirty on a first store), a miss goes
// MISS_REQ -> MISS_WAIT -> FILL, where the new entry is installed.
module l1_tag_ctrl #(
    parameter int ADDR_W   = 32,
    parameter int INDEX_W  = 8,
    parameter int OFFSET_W = 7
) (
    input  logic                clk,
    input  logic                rst,
    l1_tag_ctrl_if.slave        bus,
    output logic [31:0]         hit_count,
    output logic [31:0]         miss_count
);
    localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;

    typedef enum logic [2:0] {
        S_INIT, S_IDLE, S_COMPARE, S_MISS_REQ, S_MISS_WAIT, S_FILL
    } state_t;

    state_t             state;
    logic [INDEX_W-1:0] cnt;
    logic [INDEX_W-1:0] lat_index;
    logic [TAG_W-1:0]   lat_tag;
    logic               lat_we;

    logic [INDEX_W-1:0] req_index;
    logic [TAG_W-1:0]   req_tag;
    logic               rd_valid;
    logic               rd_dirty;
    logic [TAG_W-1:0]   rd_tag;
    logic               hit;
    logic               unused_offset;

    assign req_index     = bus.req_addr[OFFSET_W+INDEX_W-1:OFFSET_W];
    assign req_tag       = bus.req_addr[ADDR_W-1:OFFSET_W+INDEX_W];
    assign unused_offset = ^bus.req_addr[OFFSET_W-1:0];

    assign rd_valid = bus.tag_rdata[TAG_W+1];
    assign rd_dirty = bus.tag_rdata[TAG_W];
    assign rd_tag   = bus.tag_rdata[TAG_W-1:0];
    assign hit      = rd_valid && (rd_tag == lat_tag);

    // Core and tag-SRAM strobes must act in the same cycle as the accept /
    // compare, so they are decoded from state; rst forces them all low.
    always_comb begin
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        bus.resp_hit   = 1'b0;
        bus.resp_index = '0;
        bus.tag_ren    = 1'b0;
        bus.tag_raddr  = '0;
        bus.tag_wen    = 1'b0;
        bus.tag_waddr  = '0;
        bus.tag_wdata  = '0;
        if (!rst) begin
            case (state)
                S_INIT: begin
                    bus.tag_wen   = 1'b1;
                    bus.tag_waddr = cnt;
                end
                S_IDLE: begin
                    bus.req_ready = 1'b1;
                    if (bus.req_valid) begin
                        bus.tag_ren   = 1'b1;
                        bus.tag_raddr = req_index;
                    end
                end
                S_COMPARE: begin
                    if (hit) begin
                        bus.resp_valid = 1'b1;
                        bus.resp_hit   = 1'b1;
                        bus.resp_index = lat_index;
                        // First store to a clean line marks it dirty.
                        if (lat_we && !rd_dirty) begin
                            bus.tag_wen   = 1'b1;
                            bus.tag_waddr = lat_index;
                            bus.tag_wdata = {1'b1, 1'b1, lat_tag};
                        end
                    end
                end
                S_FILL: begin
                    bus.tag_wen    = 1'b1;
                    bus.tag_waddr  = lat_index;
                    bus.tag_wdata  = {1'b1, lat_we, lat_tag};
                    bus.resp_valid = 1'b1;
                    bus.resp_index = lat_index;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state               <= S_INIT;
            cnt                 <= '0;
            lat_index           <= '0;
            lat_tag             <= '0;
            lat_we              <= 1'b0;
            bus.mem_req_valid   <= 1'b0;
            bus.mem_req_addr    <= '0;
            bus.mem_req_wb      <= 1'b0;
            bus.mem_req_wb_addr <= '0;
        end else begin
            case (state)
                S_INIT: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == '1) state <= S_IDLE;
                end
                S_IDLE: begin
                    if (bus.req_valid) begin
                        lat_index <= req_index;
                        lat_tag   <= req_tag;
                        lat_we    <= bus.req_we;
                        state     <= S_COMPARE;
                    end
                end
                S_COMPARE: begin
                    if (hit) begin
                        state <= S_IDLE;
                    end else begin
                        // Victim entry is only on tag_rdata this cycle, so the
                        // write-back fields are captured straight into the request.
                        bus.mem_req_valid   <= 1'b1;
                        bus.mem_req_addr    <= {lat_tag, lat_index, {OFFSET_W{1'b0}}};
                        bus.mem_req_wb      <= rd_valid && rd_dirty;
                        bus.mem_req_wb_addr <= {rd_tag, lat_index, {OFFSET_W{1'b0}}};
                        state               <= S_MISS_REQ;
                    end
                end
                S_MISS_REQ: begin
                    if (bus.mem_req_ready) begin
                        bus.mem_req_valid   <= 1'b0;
                        bus.mem_req_addr    <= '0;
                        bus.mem_req_wb      <= 1'b0;
                        bus.mem_req_wb_addr <= '0;
                        state               <= S_MISS_WAIT;
                    end
                end
                S_MISS_WAIT: begin
                    if (bus.mem_fill_done) state <= S_FILL;
                end
                S_FILL: begin
                    state <= S_IDLE;
                end
                default: state <= S_INIT;
            endcase
        end
    end

`ifdef L1_TAG_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (bus.resp_valid) begin
            if (bus.resp_hit) begin
                if (hit_count != '1) hit_count <= hit_count + 32'd1;
            end else begin
                if (miss_count != '1) miss_count <= miss_count + 32'd1;
            end
        end
    end
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule

// File: tb/tb_l1_tag_ctrl.sv
// Directed bench for l1_tag_ctrl: a behavioural 1R1W tag SRAM model, a table
// of request vectors with hand-computed outcomes, and hand-written sequences
// for the INIT sweep, arbiter back-pressure and reset during a miss.
module tb_l1_tag_ctrl;
    localparam int ADDR_W   = 32;
    localparam int INDEX_W  = 8;
    localparam int OFFSET_W = 7;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    always #5 clk = ~clk;

    l1_tag_ctrl_if #(.ADDR_W(ADDR_W), .INDEX_W(INDEX_W), .OFFSET_W(OFFSET_W)) bus ();

    l1_tag_ctrl #(.ADDR_W(ADDR_W), .INDEX_W(INDEX_W), .OFFSET_W(OFFSET_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    // Tag SRAM model: 1-cycle read latency, write and read on the same edge.
    logic [18:0] sram [256];
    initial begin
        for (int i = 0; i < 256; i++) sram[i] = 19'h7FFFF;
        bus.tag_rdata = '0;
    end
    always @(posedge clk) begin
        if (bus.tag_wen) sram[bus.tag_waddr] <= bus.tag_wdata;
        if (bus.tag_ren) bus.tag_rdata <= sram[bus.tag_raddr];
    end

    int passed = 0;
    int total  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic        hit;
        logic        cmp_wen;
        logic [18:0] cmp_wdata;
        logic        wb;
        logic [31:0] wb_addr;
        logic [18:0] fill_wdata;
        int          stall;
    } vec_t;

    vec_t vecs [12];

    // Releases rst at a negedge and checks the full 256-entry clear sweep.
    task automatic release_and_sweep(input string tagname);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 256; i++) begin
            if (i != 0) @(negedge clk);
            #1;
            chk({tagname, ".sweep"},
                {bus.tag_wen, bus.tag_waddr, bus.tag_wdata, bus.req_ready, bus.tag_ren},
                {1'b1, 8'(i), 19'h0, 1'b0, 1'b0});
        end
        @(negedge clk);
        #1;
        chk({tagname, ".ready"}, {bus.req_ready, bus.tag_wen}, 2'b10);
    endtask

    task automatic run_req(input vec_t v, input int n);
        logic [7:0]  idx;
        logic [31:0] line;
        string       nm;
        idx  = v.addr[14:7];
        line = {v.addr[31:7], 7'b0};
        nm   = $sformatf("v%0d", n);

        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_addr  = v.addr;
        bus.req_we    = v.we;
        #1;
        chk({nm, ".accept"}, {bus.req_ready, bus.tag_ren, bus.tag_raddr}, {1'b1, 1'b1, idx});

        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_addr  = $urandom;
        bus.req_we    = 1'(v.we ^ 1'b1);
        #1;
        chk({nm, ".cmp_resp"}, {bus.resp_valid, bus.resp_hit, bus.req_ready, bus.tag_ren},
            {v.hit, v.hit, 1'b0, 1'b0});
        if (v.hit) chk({nm, ".cmp_index"}, bus.resp_index, idx);
        chk({nm, ".cmp_wen"}, bus.tag_wen, v.cmp_wen);
        if (v.cmp_wen) chk({nm, ".cmp_wr"}, {bus.tag_waddr, bus.tag_wdata}, {idx, v.cmp_wdata});
        chk({nm, ".cmp_mreq"}, bus.mem_req_valid, 1'b0);

        if (!v.hit) begin
            for (int s = 0; s <= v.stall; s++) begin
                @(negedge clk);
                bus.mem_req_ready = (s == v.stall);
                #1;
                chk({nm, ".mreq"}, {bus.mem_req_valid, bus.mem_req_wb, bus.mem_req_addr},
                    {1'b1, v.wb, line});
                chk({nm, ".mreq_wb_addr"}, bus.mem_req_wb_addr, v.wb_addr);
                chk({nm, ".mreq_quiet"}, {bus.resp_valid, bus.tag_wen, bus.req_ready}, 3'b000);
            end
            @(negedge clk);
            bus.mem_req_ready = 1'b0;
            #1;
            chk({nm, ".wait"}, {bus.mem_req_valid, bus.resp_valid, bus.tag_wen}, 3'b000);
            @(negedge clk);
            bus.mem_fill_done = 1'b1;
            #1;
            chk({nm, ".wait_done"}, {bus.mem_req_valid, bus.resp_valid, bus.tag_wen}, 3'b000);
            @(negedge clk);
            bus.mem_fill_done = 1'b0;
            #1;
            chk({nm, ".fill"},
                {bus.tag_wen, bus.tag_waddr, bus.tag_wdata, bus.resp_valid, bus.resp_hit, bus.resp_index},
                {1'b1, idx, v.fill_wdata, 1'b1, 1'b0, idx});
        end
    endtask

    initial begin
        bus.req_valid     = 1'b0;
        bus.req_addr      = '0;
        bus.req_we        = 1'b0;
        bus.mem_req_ready = 1'b0;
        bus.mem_fill_done = 1'b0;

        //          addr           we    hit   cwen  cwdata    wb    wb_addr        fill      stall
        vecs[0]  = '{32'h0000_1280, 1'b0, 1'b0, 1'b0, 19'h0,     1'b0, 32'h0000_1280, 19'h40000, 0};
        vecs[1]  = '{32'h0000_12A4, 1'b0, 1'b1, 1'b0, 19'h0,     1'b0, 32'h0,         19'h0,     0};
        vecs[2]  = '{32'h0000_1290, 1'b1, 1'b1, 1'b1, 19'h60000, 1'b0, 32'h0,         19'h0,     0};
        vecs[3]  = '{32'h0001_1280, 1'b0, 1'b0, 1'b0, 19'h0,     1'b1, 32'h0000_1280, 19'h40002, 3};
        vecs[4]  = '{32'h0001_1200, 1'b1, 1'b0, 1'b0, 19'h0,     1'b0, 32'h0000_1200, 19'h60002, 1};
        vecs[5]  = '{32'h0001_1210, 1'b1, 1'b1, 1'b0, 19'h0,     1'b0, 32'h0,         19'h0,     0};
        vecs[6]  = '{32'h0001_1290, 1'b0, 1'b1, 1'b0, 19'h0,     1'b0, 32'h0,         19'h0,     0};
        vecs[7]  = '{32'h0001_12FF, 1'b1, 1'b1, 1'b1, 19'h60002, 1'b0, 32'h0,         19'h0,     0};
        vecs[8]  = '{32'h7FFF_FF80, 1'b0, 1'b0, 1'b0, 19'h0,     1'b0, 32'h0000_7F80, 19'h4FFFF, 0};
        vecs[9]  = '{32'hFFFF_FF80, 1'b0, 1'b0, 1'b0, 19'h0,     1'b0, 32'h7FFF_FF80, 19'h5FFFF, 2};
        vecs[10] = '{32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 19'h0,     1'b0, 32'h0,         19'h0,     0};
        vecs[11] = '{32'h0000_1200, 1'b0, 1'b0, 1'b0, 19'h0,     1'b1, 32'h0001_1200, 19'h40000, 0};

        // Held in reset: every output low.
        repeat (3) @(negedge clk);
        #1;
        chk("rst.outs",
            {bus.req_ready, bus.resp_valid, bus.resp_hit, bus.tag_ren, bus.tag_wen,
             bus.mem_req_valid, bus.mem_req_wb},
            7'b0);
        chk("rst.addrs", {bus.tag_waddr, bus.tag_wdata, bus.resp_index, bus.tag_raddr}, 43'h0);
        chk("rst.counters", {hit_count, miss_count}, 64'h0);

        release_and_sweep("init");

        // A stray fill-done pulse in IDLE must not produce a response.
        @(negedge clk);
        bus.mem_fill_done = 1'b1;
        #1;
        @(negedge clk);
        bus.mem_fill_done = 1'b0;
        #1;
        chk("stray_fill", {bus.resp_valid, bus.tag_wen, bus.req_ready}, 3'b001);

        for (int i = 0; i < 12; i++) run_req(vecs[i], i);

`ifdef L1_TAG_PERF_CNT_EN
        chk("perf.hits",   hit_count,  32'd6);
        chk("perf.misses", miss_count, 32'd6);
`else
        chk("perf.hits",   hit_count,  32'd0);
        chk("perf.misses", miss_count, 32'd0);
`endif

        // Reset while waiting for a fill (idx 0, tag 0x154, cold miss).
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h00AA_0000;
        bus.req_we    = 1'b0;
        @(negedge clk);
        bus.req_valid = 1'b0;
        #1;
        chk("rw.cmp", {bus.resp_valid, bus.tag_wen}, 2'b00);
        @(negedge clk);
        bus.mem_req_ready = 1'b1;
        #1;
        chk("rw.mreq", {bus.mem_req_valid, bus.mem_req_addr}, {1'b1, 32'h00AA_0000});
        @(negedge clk);
        bus.mem_req_ready = 1'b0;
        rst = 1'b1;
        #1;
        chk("rw.rst_outs", {bus.mem_req_valid, bus.resp_valid, bus.tag_wen, bus.req_ready}, 4'b0);
        @(negedge clk);
        bus.mem_fill_done = 1'b1;
        #1;
        chk("rw.rst_hold", {bus.mem_req_valid, bus.resp_valid, bus.tag_wen}, 3'b0);
        chk("rw.counters", {hit_count, miss_count}, 64'h0);
        @(negedge clk);
        bus.mem_fill_done = 1'b0;
        release_and_sweep("rw");

        // Reset while a request is presented to the arbiter: valid drops next cycle.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h00AA_0040;
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("rq.mreq", {bus.mem_req_valid, bus.mem_req_wb, bus.mem_req_addr}, {1'b1, 1'b0, 32'h00AA_0000});
        chk("rq.wb_addr", bus.mem_req_wb_addr, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("rq.dropped", {bus.mem_req_valid, bus.mem_req_wb, bus.mem_req_addr}, 34'h0);
        release_and_sweep("rq");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
